sume_param: RTL and testbench



---
 rtl/sume_pkg.sv | 15 +
 rtl/sume_param_if.sv | 30 +++
 rtl/sume_param_digit_shreg.sv | 38 +++
 rtl/sume_param.sv | 122 ++++++++++++
 tb/tb_sume_param.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/sume_pkg.sv
// Shared definitions for the serial-digit adder/subtractor.
//   state_t : controller states (LOAD_A, LOAD_B, COMPUTE), 2-bit encoding
//   OP_ADD / OP_SUB : encoding of the op_sub select line
package sume_pkg;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    COMPUTE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/sume_param_if.sv
// Digit bus and result bus between the digit-entry front end, the adder and
// the display driver.
//   master : front end side (drives sample, sample_valid, op_sub)
//   slave  : adder side (drives sample_ready, sum, carry, sum_valid, loading_b)
interface sume_param_if #(
  parameter int DIGIT_W  = 4,
  parameter int N_DIGITS = 3
);
  localparam int SUM_W = DIGIT_W * N_DIGITS;

  logic [DIGIT_W-1:0] sample;
  logic               sample_valid;
  logic               sample_ready;
  logic               op_sub;
  logic [SUM_W-1:0]   sum;
  logic               carry;
  logic               sum_valid;
  logic               loading_b;

  modport master (
    output sample, sample_valid, op_sub,
    input  sample_ready, sum, carry, sum_valid, loading_b
  );

  modport slave (
    input  sample, sample_valid, op_sub,
    output sample_ready, sum, carry, sum_valid, loading_b
  );

endinterface

// File: rtl/sume_param_digit_shreg.sv
// Operand shift register: digits arrive MSB first, so each new digit enters
// the LSBs while the held value moves up by one digit.
//   clk, reset : clock and synchronous active-high reset
//   clr        : clear the operand (after it has been consumed)
//   shift_en   : shift din in this cycle
//   din        : incoming digit
//   q          : assembled operand, DIGIT_W*N_DIGITS bits
module digit_shreg #(
  parameter int DIGIT_W  = 4,
  parameter int N_DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clr,
  input  logic                          shift_en,
  input  logic [DIGIT_W-1:0]            din,
  output logic [DIGIT_W*N_DIGITS-1:0]   q
);
  localparam int SUM_W = DIGIT_W * N_DIGITS;

  logic [SUM_W-1:0]         r_q;
  logic [SUM_W+DIGIT_W-1:0] w_cat;

  // Concatenate then keep the low SUM_W bits; this also covers N_DIGITS=1,
  // where the old value is dropped entirely.
  assign w_cat = {r_q, din};

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_q <= '0;
    end else if (shift_en) begin
      r_q <= w_cat[SUM_W-1:0];
    end
  end

  assign q = r_q;

endmodule

// File: rtl/sume_param.sv
// Parametrised serial-digit adder/subtractor.
// Collects operand A then operand B, MSB digit first, over a valid/ready
// digit bus, then adds or subtracts them in a single COMPUTE cycle and
// presents a registered result with carry/borrow and a one-cycle done pulse.
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : sume_param_if slave (sample/sample_valid/sample_ready/op_sub in,
//           sum/carry/sum_valid/loading_b out)
module sume_param
  import sume_pkg::*;
#(
  parameter int DIGIT_W  = 4,
  parameter int N_DIGITS = 3
) (
  input  logic        clk,
  input  logic        reset,
  sume_param_if.slave bus
);
  localparam int SUM_W = DIGIT_W * N_DIGITS;
  localparam int CNT_W = $clog2(N_DIGITS + 1);
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N_DIGITS - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_op;
  logic [SUM_W-1:0]   r_sum;
  logic               r_carry;
  logic               r_sum_valid;

  logic               w_ready;
  logic               w_accept;
  logic               w_last;
  logic               w_shift_a;
  logic               w_shift_b;
  logic               w_clr;
  logic [SUM_W-1:0]   w_a;
  logic [SUM_W-1:0]   w_b;

  // One extra bit holds the carry on add; on subtract the same bit is the
  // borrow, set exactly when a < b as unsigned values.
  function automatic logic [SUM_W:0] f_addsub(input logic [SUM_W-1:0] a,
                                              input logic [SUM_W-1:0] b,
                                              input logic             op);
    if (op == OP_ADD) return {1'b0, a} + {1'b0, b};
    return {1'b0, a} - {1'b0, b};
  endfunction

  digit_shreg #(.DIGIT_W(DIGIT_W), .N_DIGITS(N_DIGITS)) u_opa (
    .clk      (clk),
    .reset    (reset),
    .clr      (w_clr),
    .shift_en (w_shift_a),
    .din      (bus.sample),
    .q        (w_a)
  );

  digit_shreg #(.DIGIT_W(DIGIT_W), .N_DIGITS(N_DIGITS)) u_opb (
    .clk      (clk),
    .reset    (reset),
    .clr      (w_clr),
    .shift_en (w_shift_b),
    .din      (bus.sample),
    .q        (w_b)
  );

  assign w_ready   = (r_state != COMPUTE);
  assign w_accept  = bus.sample_valid && w_ready;
  assign w_last    = (r_cnt == LAST_DIGIT);
  assign w_shift_a = w_accept && (r_state == LOAD_A);
  assign w_shift_b = w_accept && (r_state == LOAD_B);
  // Operands are consumed in COMPUTE, so they can be cleared on that edge.
  assign w_clr     = (r_state == COMPUTE);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      LOAD_A: begin
        if (w_accept) begin
          w_cnt_nxt = w_last ? '0 : r_cnt + 1'b1;
          if (w_last) w_state_nxt = LOAD_B;
        end
      end
      LOAD_B: begin
        if (w_accept) begin
          w_cnt_nxt = w_last ? '0 : r_cnt + 1'b1;
          if (w_last) w_state_nxt = COMPUTE;
        end
      end
      COMPUTE: w_state_nxt = LOAD_A;
      default: w_state_nxt = LOAD_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= LOAD_A;
      r_cnt       <= '0;
      r_op        <= OP_ADD;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_sum_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sum_valid <= (r_state == COMPUTE);
      // The operation is fixed by the first digit of A; later changes wait
      // for the next operation.
      if (w_shift_a && (r_cnt == '0)) r_op <= bus.op_sub;
      if (r_state == COMPUTE) {r_carry, r_sum} <= f_addsub(w_a, w_b, r_op);
    end
  end

  assign bus.sample_ready = w_ready;
  assign bus.loading_b    = (r_state == LOAD_B);
  assign bus.sum          = r_sum;
  assign bus.carry        = r_carry;
  assign bus.sum_valid    = r_sum_valid;

endmodule

// File: tb/tb_sume_param.sv
module tb_sume_param;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sume_param_if #(.DIGIT_W(4), .N_DIGITS(3)) bus_m ();
  sume_param_if #(.DIGIT_W(8), .N_DIGITS(2)) bus_8 ();
  sume_param_if #(.DIGIT_W(4), .N_DIGITS(1)) bus_1 ();

  sume_param #(.DIGIT_W(4), .N_DIGITS(3)) u_m (.clk(clk), .reset(reset), .bus(bus_m));
  sume_param #(.DIGIT_W(8), .N_DIGITS(2)) u_8 (.clk(clk), .reset(reset), .bus(bus_8));
  sume_param #(.DIGIT_W(4), .N_DIGITS(1)) u_1 (.clk(clk), .reset(reset), .bus(bus_1));

  typedef struct {
    logic [15:0] s;
    logic        c;
  } exp_t;

  exp_t qm[$];
  exp_t q8[$];
  exp_t q1[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_acc = 0;
  int last_b_edge = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitors: every sum_valid cycle consumes one expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (bus_m.sum_valid === 1'b1) begin
      if (qm.size() == 0) chk("m_unexpected_sum_valid", 1, 0);
      else begin
        e = qm.pop_front();
        chk("m_sum", 32'(bus_m.sum), 32'(e.s[11:0]));
        chk("m_carry", 32'(bus_m.carry), 32'(e.c));
        chk("m_latency_edge", cyc, last_b_edge + 1);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus_8.sum_valid === 1'b1) begin
      if (q8.size() == 0) chk("w8_unexpected_sum_valid", 1, 0);
      else begin
        e = q8.pop_front();
        chk("w8_sum", 32'(bus_8.sum), 32'(e.s));
        chk("w8_carry", 32'(bus_8.carry), 32'(e.c));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus_1.sum_valid === 1'b1) begin
      if (q1.size() == 0) chk("n1_unexpected_sum_valid", 1, 0);
      else begin
        e = q1.pop_front();
        chk("n1_sum", 32'(bus_1.sum), 32'(e.s[3:0]));
        chk("n1_carry", 32'(bus_1.carry), 32'(e.c));
      end
    end
  end

  // All senders are called at a negedge and return at a negedge.
  task automatic send_m(input logic [3:0] d, input int gap);
    int n;
    repeat (gap) begin
      bus_m.sample_valid = 1'b0;
      bus_m.sample = 4'($urandom);
      @(negedge clk);
    end
    bus_m.sample = d;
    bus_m.sample_valid = 1'b1;
    n = 0;
    while (bus_m.sample_ready !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (n >= 8) chk("m_ready_timeout", 0, 1);
    @(posedge clk);
    #1 last_acc = cyc;
    @(negedge clk);
    bus_m.sample_valid = 1'b0;
    bus_m.sample = 4'($urandom);
  endtask

  task automatic send_8(input logic [7:0] d);
    int n;
    bus_8.sample = d;
    bus_8.sample_valid = 1'b1;
    n = 0;
    while (bus_8.sample_ready !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (n >= 8) chk("w8_ready_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    bus_8.sample_valid = 1'b0;
  endtask

  task automatic send_1(input logic [3:0] d);
    int n;
    bus_1.sample = d;
    bus_1.sample_valid = 1'b1;
    n = 0;
    while (bus_1.sample_ready !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (n >= 8) chk("n1_ready_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    bus_1.sample_valid = 1'b0;
  endtask

  // One full operation on the default instance; tog flips op_sub after the
  // first digit so that the latched operation can be confirmed.
  task automatic run_m(input logic [11:0] a, input logic [11:0] b, input logic op,
                       input int gap, input logic tog,
                       input logic [11:0] es, input logic ec, input string nm);
    exp_t e;
    e.s = 16'(es);
    e.c = ec;
    qm.push_back(e);
    bus_m.op_sub = op;
    for (int i = 0; i < 3; i++) begin
      send_m(a[11-4*i -: 4], gap);
      if (tog) bus_m.op_sub = ~op;
      if (i == 1) chk({nm, "_loading_b_after_a2"}, 32'(bus_m.loading_b), 0);
    end
    chk({nm, "_loading_b_after_a3"}, 32'(bus_m.loading_b), 1);
    for (int i = 0; i < 3; i++) begin
      send_m(b[11-4*i -: 4], gap);
      if (i == 1) chk({nm, "_loading_b_after_b2"}, 32'(bus_m.loading_b), 1);
    end
    last_b_edge = last_acc;
    chk({nm, "_ready_in_compute"}, 32'(bus_m.sample_ready), 0);
    chk({nm, "_loading_b_after_b3"}, 32'(bus_m.loading_b), 0);
    chk({nm, "_no_early_valid"}, 32'(bus_m.sum_valid), 0);
    bus_m.op_sub = 1'b0;
  endtask

  initial begin
    exp_t e;
    reset = 1'b1;
    bus_m.sample = '0; bus_m.sample_valid = 1'b0; bus_m.op_sub = 1'b0;
    bus_8.sample = '0; bus_8.sample_valid = 1'b0; bus_8.op_sub = 1'b0;
    bus_1.sample = '0; bus_1.sample_valid = 1'b0; bus_1.op_sub = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_sum", 32'(bus_m.sum), 0);
    chk("rst_carry", 32'(bus_m.carry), 0);
    chk("rst_sum_valid", 32'(bus_m.sum_valid), 0);
    chk("rst_loading_b", 32'(bus_m.loading_b), 0);
    chk("rst_ready", 32'(bus_m.sample_ready), 1);

    run_m(12'h123, 12'h456, 1'b0, 0, 1'b0, 12'h579, 1'b0, "add_basic");
    repeat (4) @(negedge clk);
    chk("hold_sum", 32'(bus_m.sum), 32'h579);
    chk("hold_carry", 32'(bus_m.carry), 0);

    run_m(12'hFFF, 12'h001, 1'b0, 0, 1'b0, 12'h000, 1'b1, "add_ovf");
    run_m(12'h000, 12'h000, 1'b0, 0, 1'b0, 12'h000, 1'b0, "add_zero");
    run_m(12'h100, 12'h001, 1'b1, 0, 1'b0, 12'h0FF, 1'b0, "sub_basic");
    run_m(12'h001, 12'h002, 1'b1, 0, 1'b0, 12'hFFF, 1'b1, "sub_borrow");
    run_m(12'h2A7, 12'h015, 1'b0, 2, 1'b1, 12'h2BC, 1'b0, "gaps_toggle");
    repeat (3) @(negedge clk);

    // Reset mid-load with a valid digit present: partial A is discarded.
    bus_m.op_sub = 1'b0;
    send_m(4'h1, 0);
    send_m(4'h2, 0);
    reset = 1'b1;
    bus_m.sample = 4'h7;
    bus_m.sample_valid = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus_m.sample_valid = 1'b0;
    chk("midrst_sum", 32'(bus_m.sum), 0);
    chk("midrst_carry", 32'(bus_m.carry), 0);
    chk("midrst_sum_valid", 32'(bus_m.sum_valid), 0);
    chk("midrst_loading_b", 32'(bus_m.loading_b), 0);
    run_m(12'h333, 12'h111, 1'b0, 0, 1'b0, 12'h444, 1'b0, "after_rst");
    repeat (3) @(negedge clk);

    e.s = 16'h0000; e.c = 1'b1; q8.push_back(e);
    send_8(8'hFF); send_8(8'hFF); send_8(8'h00); send_8(8'h01);
    repeat (3) @(negedge clk);

    e.s = 16'h0001; e.c = 1'b1; q1.push_back(e);
    send_1(4'h9); send_1(4'h8);
    repeat (4) @(negedge clk);

    chk("m_pending", qm.size(), 0);
    chk("w8_pending", q8.size(), 0);
    chk("n1_pending", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
